sa_request_arbiter: RTL and testbench

Round-robin scheduler that shares one `topSystolicArray` instance between `R` independent requesters. It accepts one N×N int8 matrix-multiply job at a time over a valid/ready handshake and registers the operands. It then pulses the array's start input, waits for the array's result-valid, and returns the 32-bit result matrix with the requester ID over a valid/ready response channel. It sits between the ViT attention/MLP engines and the array.

---
 rtl/sa_request_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sa_request_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_request_arbiter.sv
// Round-robin job scheduler for one shared systolic array: grant->response is 3N+1 cycles; one job in flight,
// response held until i_rspReady and no request accepted until it drains. SA_ARB_WATCHDOG_EN adds a BUSY timeout.
module sa_request_arbiter #(
  parameter int N       = 16,
  parameter int R       = 4,
  parameter int TIMEOUT = 3 * N + 8,
  localparam int ID_W   = (R > 1) ? $clog2(R) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_srst,
  input  logic [R-1:0]                    i_reqValid,
  output logic [R-1:0]                    o_reqReady,
  input  logic [R-1:0][N-1:0][N-1:0][7:0] i_reqA,
  input  logic [R-1:0][N-1:0][N-1:0][7:0] i_reqB,
  output logic                            o_rspValid,
  input  logic                            i_rspReady,
  output logic [ID_W-1:0]                 o_rspId,
  output logic [N-1:0][N-1:0][31:0]       o_rspC,
  output logic                            o_rspErr,
  output logic [N-1:0][N-1:0][7:0]        o_saA,
  output logic [N-1:0][N-1:0][7:0]        o_saB,
  output logic                            o_saValidInput,
  input  logic [N-1:0][N-1:0][31:0]       i_saC,
  input  logic                            i_saValidResult,
  output logic                            o_busy
);

  if (R < 1 || R > 16) begin : g_bad_r
    $error("sa_request_arbiter: R=%0d outside legal range 1..16", R);
  end
  if (N < 3 || N > 256) begin : g_bad_n
    $error("sa_request_arbiter: N=%0d outside legal range 3..256", N);
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESPOND
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [N-1:0][N-1:0][7:0]  a_q;
  logic [N-1:0][N-1:0][7:0]  b_q;
  logic [N-1:0][N-1:0][31:0] rsp_c_q;
  logic [ID_W-1:0]           id_q;
  logic [ID_W-1:0]           ptr_q;
  logic [ID_W-1:0]           ptr_next;
  logic [ID_W-1:0]           grant_idx;
  logic                      grant_vld;
  logic                      req_fire;
  logic                      rsp_fire;
  logic                      result_take;

`ifdef SA_ARB_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;
  logic            timeout_hit;
`endif

  // Rotating priority: first valid requester at or above ptr_q, wrapping modulo R.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] idx;
    cand      = 0;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < R; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= R) cand = cand - R;
      idx = ID_W'(cand);
      if (!grant_vld && i_reqValid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    o_reqReady = '0;
    for (int i = 0; i < R; i++) begin
      o_reqReady[i] = (state_q == ST_IDLE) && !i_srst && grant_vld && (int'(grant_idx) == i);
    end
  end

  assign ptr_next = (int'(id_q) == R - 1) ? '0 : id_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_srst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    o_saValidInput = 1'b0;
    o_rspValid     = 1'b0;
    req_fire       = 1'b0;
    rsp_fire       = 1'b0;
    result_take    = 1'b0;
`ifdef SA_ARB_WATCHDOG_EN
    timeout_hit    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld && !i_srst) begin
          req_fire = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        o_saValidInput = 1'b1;
        state_d        = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_saValidResult) begin
          result_take = 1'b1;
          state_d     = ST_RESPOND;
        end
`ifdef SA_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_RESPOND;
        end
`endif
      end
      ST_RESPOND: begin
        o_rspValid = 1'b1;
        if (i_rspReady) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      rsp_c_q <= '0;
    end else begin
      if (req_fire) begin
        a_q  <= i_reqA[grant_idx];
        b_q  <= i_reqB[grant_idx];
        id_q <= grant_idx;
      end
      if (result_take) rsp_c_q <= i_saC;
`ifdef SA_ARB_WATCHDOG_EN
      if (timeout_hit) rsp_c_q <= '0;
`endif
      if (rsp_fire) ptr_q <= ptr_next;
    end
  end

`ifdef SA_ARB_WATCHDOG_EN
  // Counter restarts on every launch so each job gets the full TIMEOUT window.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_LAUNCH)    wd_cnt_q <= '0;
      else if (state_q == ST_BUSY) wd_cnt_q <= wd_cnt_q + 1'b1;
      if (timeout_hit)             err_q <= 1'b1;
      else if (rsp_fire)           err_q <= 1'b0;
    end
  end

  assign o_rspErr = err_q;
`else
  assign o_rspErr = 1'b0;
`endif

  assign o_saA   = a_q;
  assign o_saB   = b_q;
  assign o_rspC  = rsp_c_q;
  assign o_rspId = id_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sa_request_arbiter.sv
// Directed bench for sa_request_arbiter at N=4, R=4 with a behavioural systolic-array model.
module tb_sa_request_arbiter;

  localparam int N       = 4;
  localparam int R       = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 3 * N + 8;

  typedef logic [N-1:0][N-1:0][7:0]  mat8_t;
  typedef logic [N-1:0][N-1:0][31:0] mat32_t;

  logic                            i_clk;
  logic                            i_srst;
  logic [R-1:0]                    i_reqValid;
  logic [R-1:0]                    o_reqReady;
  logic [R-1:0][N-1:0][N-1:0][7:0] i_reqA;
  logic [R-1:0][N-1:0][N-1:0][7:0] i_reqB;
  logic                            o_rspValid;
  logic                            i_rspReady;
  logic [ID_W-1:0]                 o_rspId;
  mat32_t                          o_rspC;
  logic                            o_rspErr;
  mat8_t                           o_saA;
  mat8_t                           o_saB;
  logic                            o_saValidInput;
  mat32_t                          i_saC;
  logic                            i_saValidResult;
  logic                            o_busy;

  int     n_checks;
  int     n_fail;
  int     spur_cnt;
  logic   sa_block;
  mat32_t spur_c;
  mat8_t  op_a [R];
  mat8_t  op_b [R];

  sa_request_arbiter #(.N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .i_clk           (i_clk),
    .i_srst          (i_srst),
    .i_reqValid      (i_reqValid),
    .o_reqReady      (o_reqReady),
    .i_reqA          (i_reqA),
    .i_reqB          (i_reqB),
    .o_rspValid      (o_rspValid),
    .i_rspReady      (i_rspReady),
    .o_rspId         (o_rspId),
    .o_rspC          (o_rspC),
    .o_rspErr        (o_rspErr),
    .o_saA           (o_saA),
    .o_saB           (o_saB),
    .o_saValidInput  (o_saValidInput),
    .i_saC           (i_saC),
    .i_saValidResult (i_saValidResult),
    .o_busy          (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic mat8_t mk_mat(input int base);
    mat8_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = 8'(base + i * N + j);
    return m;
  endfunction

  function automatic mat32_t matmul(input mat8_t a, input mat8_t b);
    mat32_t c;
    int     s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        c[i][j] = 32'(s);
      end
    return c;
  endfunction

  // Array model: result-valid 3N-1 cycles after the launch cycle; cleared by the shared reset.
  initial begin
    int     cd;
    int     spur_seen;
    mat32_t pend;
    cd = 0;
    spur_seen = 0;
    pend = '0;
    i_saValidResult = 1'b0;
    i_saC = '1;
    forever begin
      @(negedge i_clk);
      if (i_srst) cd = 0;
      else if (o_saValidInput) begin
        pend = matmul(o_saA, o_saB);
        cd = 3 * N - 1;
      end
      @(posedge i_clk);
      #1;
      i_saValidResult = 1'b0;
      i_saC = '1;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !sa_block) begin
          i_saValidResult = 1'b1;
          i_saC = pend;
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        i_saValidResult = 1'b1;
        i_saC = spur_c;
      end
    end
  end

  task automatic do_reset();
    i_srst = 1'b1;
    i_reqValid = '0;
    i_rspReady = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_srst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_checks++; if (o_reqReady !== 4'b0000) begin n_fail++; $display("FAIL rst_reqReady: got %b exp 0000", o_reqReady); end
    n_checks++; if ({o_rspValid, o_saValidInput, o_busy, o_rspErr} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b exp 0000", {o_rspValid, o_saValidInput, o_busy, o_rspErr}); end
    n_checks++; if (o_rspId !== '0 || o_rspC !== '0) begin n_fail++; $display("FAIL rst_rsp: id %0d C %h exp 0", o_rspId, o_rspC); end
    n_checks++; if (o_saA !== '0 || o_saB !== '0) begin n_fail++; $display("FAIL rst_operands: A %h B %h exp 0", o_saA, o_saB); end
    @(posedge i_clk); #1;
    i_srst = 1'b0;
    i_reqValid = '0;
  endtask

  task automatic test_single();
    mat8_t  a_id;
    mat8_t  b3;
    mat32_t c3;
    int     lat;
    int     launches;
    logic   got;
    a_id = '0;
    for (int i = 0; i < N; i++) a_id[i][i] = 8'd1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        b3[i][j] = 8'd3;
        c3[i][j] = 32'd3;
      end
    do_reset();
    i_reqA[2] = a_id;
    i_reqB[2] = b3;
    i_reqValid = 4'b0100;
    @(negedge i_clk);
    n_checks++; if (o_reqReady !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b exp 0100", o_reqReady); end
    lat = 0; got = 1'b0; launches = 0;
    while (!got && lat < 60) begin
      @(posedge i_clk); #1;
      lat++;
      i_reqValid = '0;
      @(negedge i_clk);
      if (o_saValidInput) launches++;
      if (lat == 1) begin
        n_checks++; if (o_saValidInput !== 1'b1 || o_saA !== a_id || o_saB !== b3) begin n_fail++; $display("FAIL single_launch: vi %b A %h B %h", o_saValidInput, o_saA, o_saB); end
        n_checks++; if (o_reqReady !== 4'b0000) begin n_fail++; $display("FAIL single_ready_launch: got %b exp 0000", o_reqReady); end
      end
      if (o_rspValid) got = 1'b1;
    end
    n_checks++; if (!got || lat != 13) begin n_fail++; $display("FAIL single_latency: got %0d (seen %b) exp 13", lat, got); end
    n_checks++; if (launches != 1) begin n_fail++; $display("FAIL single_launch_count: got %0d exp 1", launches); end
    n_checks++; if (o_rspId !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d exp 2", o_rspId); end
    n_checks++; if (o_rspC !== c3) begin n_fail++; $display("FAIL single_c: got %h exp %h", o_rspC, c3); end
    i_rspReady = 1'b1;
    @(posedge i_clk); #1;
    i_rspReady = 1'b0;
    @(negedge i_clk);
    n_checks++; if (o_rspValid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL single_done: rspValid %b busy %b exp 0 0", o_rspValid, o_busy); end
  endtask

  task automatic test_back_to_back();
    int exp_order [5];
    int g_idx [5];
    int g_cyc [5];
    int ng, nr, launches, cyc;
    exp_order = '{0, 1, 2, 3, 0};
    g_idx = '{0, 0, 0, 0, 0};
    g_cyc = '{0, 0, 0, 0, 0};
    do_reset();
    for (int r = 0; r < R; r++) begin
      i_reqA[r] = op_a[r];
      i_reqB[r] = op_b[r];
    end
    i_reqValid = '1;
    i_rspReady = 1'b1;
    ng = 0; nr = 0; launches = 0; cyc = 0;
    while ((ng < 5 || nr < 5) && cyc < 200) begin
      @(negedge i_clk);
      if (o_saValidInput) launches++;
      if (o_reqReady != '0 && ng < 5) begin
        for (int i = 0; i < R; i++) if (o_reqReady[i]) g_idx[ng] = i;
        g_cyc[ng] = cyc;
        ng++;
      end
      if (o_rspValid && nr < 5) begin
        n_checks++;
        if (int'(o_rspId) != exp_order[nr] || o_rspC !== matmul(op_a[exp_order[nr]], op_b[exp_order[nr]])) begin
          n_fail++; $display("FAIL b2b_rsp%0d: id %0d C %h exp id %0d", nr, o_rspId, o_rspC, exp_order[nr]);
        end
        nr++;
      end
      @(posedge i_clk); #1;
      cyc++;
      if (ng >= 5) i_reqValid = '0;
    end
    n_checks++; if (nr != 5 || ng != 5) begin n_fail++; $display("FAIL b2b_count: grants %0d rsps %0d exp 5 5", ng, nr); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (g_idx[i] != exp_order[i]) begin n_fail++; $display("FAIL b2b_order%0d: got %0d exp %0d", i, g_idx[i], exp_order[i]); end
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (g_cyc[i] - g_cyc[i-1] != 14) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d exp 14", i, g_cyc[i] - g_cyc[i-1]); end
    end
    n_checks++; if (launches != 5) begin n_fail++; $display("FAIL b2b_launches: got %0d exp 5", launches); end
    i_rspReady = 1'b0;
  endtask

  task automatic test_backpressure();
    mat32_t exp_c;
    int     n, launches;
    logic   got;
    do_reset();
    i_reqA[1] = op_a[1]; i_reqB[1] = op_b[1];
    i_reqA[3] = op_a[3]; i_reqB[3] = op_b[3];
    exp_c = matmul(op_a[1], op_b[1]);
    i_reqValid = 4'b1010;
    @(negedge i_clk);
    n_checks++; if (o_reqReady !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b exp 0010", o_reqReady); end
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(posedge i_clk); #1;
      n++;
      @(negedge i_clk);
      if (o_rspValid) got = 1'b1;
    end
    n_checks++; if (!got || o_rspId !== 2'd1 || o_rspC !== exp_c) begin n_fail++; $display("FAIL bp_rsp: seen %b id %0d C %h exp id 1 C %h", got, o_rspId, o_rspC, exp_c); end
    launches = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      @(negedge i_clk);
      if (o_saValidInput) launches++;
      n_checks++;
      if (o_rspValid !== 1'b1 || o_rspC !== exp_c || o_rspId !== 2'd1 || o_reqReady !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold%0d: vld %b id %0d rdy %b C %h", c, o_rspValid, o_rspId, o_reqReady, o_rspC);
      end
    end
    n_checks++; if (launches != 0) begin n_fail++; $display("FAIL bp_launches: got %0d exp 0", launches); end
    @(posedge i_clk); #1;
    i_rspReady = 1'b1;
    @(negedge i_clk);
    n_checks++; if (o_reqReady !== 4'b0000 || o_rspValid !== 1'b1) begin n_fail++; $display("FAIL bp_same_cycle: rdy %b vld %b exp 0000 1", o_reqReady, o_rspValid); end
    @(posedge i_clk); #1;
    i_rspReady = 1'b0;
    @(negedge i_clk);
    n_checks++; if (o_reqReady !== 4'b1000 || o_rspValid !== 1'b0) begin n_fail++; $display("FAIL bp_next_grant: rdy %b vld %b exp 1000 0", o_reqReady, o_rspValid); end
    @(posedge i_clk); #1;
    i_reqValid = '0;
  endtask

  task automatic test_spurious();
    mat32_t exp_c;
    int     n;
    logic   got;
    do_reset();
    @(negedge i_clk);
    spur_cnt++;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL spur_idle_pulse: busy %b exp 0", o_busy); end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b0 || o_rspValid !== 1'b0 || o_rspC !== '0) begin n_fail++; $display("FAIL spur_idle_after: busy %b vld %b C %h", o_busy, o_rspValid, o_rspC); end
    i_reqA[0] = op_a[0];
    i_reqB[0] = op_b[0];
    exp_c = matmul(op_a[0], op_b[0]);
    i_reqValid = 4'b0001;
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(posedge i_clk); #1;
      n++;
      i_reqValid = '0;
      @(negedge i_clk);
      if (o_rspValid) got = 1'b1;
    end
    n_checks++; if (!got || o_rspC !== exp_c) begin n_fail++; $display("FAIL spur_job: seen %b C %h exp %h", got, o_rspC, exp_c); end
    spur_cnt++;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_checks++; if (o_rspValid !== 1'b1 || o_rspC !== exp_c || o_rspId !== 2'd0) begin n_fail++; $display("FAIL spur_respond: vld %b id %0d C %h exp 1 0 %h", o_rspValid, o_rspId, o_rspC, exp_c); end
    @(posedge i_clk); #1;
    i_rspReady = 1'b1;
    @(posedge i_clk); #1;
    i_rspReady = 1'b0;
  endtask

  task automatic test_reset_busy();
    int   n;
    logic got;
    do_reset();
    for (int r = 0; r < R; r++) begin
      i_reqA[r] = op_a[r];
      i_reqB[r] = op_b[r];
    end
    i_rspReady = 1'b1;
    i_reqValid = 4'b0100;
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(posedge i_clk); #1;
      n++;
      i_reqValid = '0;
      @(negedge i_clk);
      if (o_rspValid) got = 1'b1;
    end
    @(posedge i_clk); #1;
    i_rspReady = 1'b0;
    i_reqValid = 4'b0010;
    @(negedge i_clk);
    n_checks++; if (!got || o_reqReady !== 4'b0010) begin n_fail++; $display("FAIL rb_grant: first job %b rdy %b exp 0010", got, o_reqReady); end
    repeat (5) begin
      @(posedge i_clk); #1;
      i_reqValid = '0;
    end
    @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b1 || o_rspValid !== 1'b0) begin n_fail++; $display("FAIL rb_in_busy: busy %b vld %b exp 1 0", o_busy, o_rspValid); end
    @(posedge i_clk); #1;
    i_srst = 1'b1;
    @(posedge i_clk); #1;
    i_srst = 1'b0;
    i_reqValid = 4'b1001;
    @(negedge i_clk);
    n_checks++; if ({o_busy, o_rspValid, o_saValidInput, o_rspErr} !== 4'b0000) begin n_fail++; $display("FAIL rb_flags: got %b exp 0000", {o_busy, o_rspValid, o_saValidInput, o_rspErr}); end
    n_checks++; if (o_rspId !== '0 || o_rspC !== '0 || o_saA !== '0 || o_saB !== '0) begin n_fail++; $display("FAIL rb_values: id %0d C %h A %h B %h exp 0", o_rspId, o_rspC, o_saA, o_saB); end
    n_checks++; if (o_reqReady !== 4'b0001) begin n_fail++; $display("FAIL rb_ptr: rdy %b exp 0001", o_reqReady); end
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(posedge i_clk); #1;
      n++;
      i_reqValid = '0;
      @(negedge i_clk);
      if (o_rspValid) got = 1'b1;
    end
    n_checks++; if (!got || o_rspId !== 2'd0 || o_rspC !== matmul(op_a[0], op_b[0])) begin n_fail++; $display("FAIL rb_after: seen %b id %0d C %h", got, o_rspId, o_rspC); end
  endtask

  task automatic test_watchdog();
    int   n;
    logic got;
    do_reset();
    sa_block = 1'b1;
    i_reqA[0] = op_a[0];
    i_reqB[0] = op_b[0];
    i_reqValid = 4'b0001;
    @(negedge i_clk);
`ifdef SA_ARB_WATCHDOG_EN
    n = 0; got = 1'b0;
    while (!got && n < 3 * TIMEOUT) begin
      @(posedge i_clk); #1;
      n++;
      i_reqValid = '0;
      @(negedge i_clk);
      if (o_rspValid) got = 1'b1;
    end
    n_checks++; if (!got || n != TIMEOUT + 2) begin n_fail++; $display("FAIL wd_latency: seen %b got %0d exp %0d", got, n, TIMEOUT + 2); end
    n_checks++; if (o_rspErr !== 1'b1 || o_rspC !== '0) begin n_fail++; $display("FAIL wd_err: err %b C %h exp 1 0", o_rspErr, o_rspC); end
    @(posedge i_clk); #1;
    i_rspReady = 1'b1;
    @(posedge i_clk); #1;
    i_rspReady = 1'b0;
    @(negedge i_clk);
    n_checks++; if (o_rspErr !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL wd_clear: err %b busy %b exp 0 0", o_rspErr, o_busy); end
`else
    got = 1'b0;
    for (n = 0; n < 3 * N + 20; n++) begin
      @(posedge i_clk); #1;
      i_reqValid = '0;
      @(negedge i_clk);
      if (o_rspValid || o_rspErr) got = 1'b1;
    end
    n_checks++; if (got || o_busy !== 1'b1) begin n_fail++; $display("FAIL nowd_hang: rsp/err seen %b busy %b exp 0 1", got, o_busy); end
`endif
    sa_block = 1'b0;
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    spur_cnt = 0;
    sa_block = 1'b0;
    i_srst = 1'b1;
    i_reqValid = '1;
    i_rspReady = 1'b0;
    i_reqA = '0;
    i_reqB = '0;
    for (int r = 0; r < R; r++) begin
      op_a[r] = mk_mat(r + 1);
      op_b[r] = mk_mat(2 * r + 3);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        spur_c[i][j] = 32'h5A5A_0000 + 32'(i * N + j);

    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_spurious();
    test_reset_busy();
    test_watchdog();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
